// File: rtl/popcount_sequencer_if.sv
// rtl/popcount_sequencer_if.sv - word-in / count-out handshake bundle for popcount_sequencer
interface popcount_sequencer_if #(
  parameter int WORD_WIDTH  = 64,
  parameter int COUNT_WIDTH = 7
);
  logic [WORD_WIDTH-1:0]  word_in;
  logic                   word_valid_in;
  logic                   word_ready_out;
  logic [COUNT_WIDTH-1:0] count_out;
  logic                   count_valid_out;
  logic                   count_ready_in;
  logic                   busy_out;

  modport slave (
    input  word_in, word_valid_in, count_ready_in,
    output word_ready_out, count_out, count_valid_out, busy_out
  );

  modport master (
    output word_in, word_valid_in, count_ready_in,
    input  word_ready_out, count_out, count_valid_out, busy_out
  );
endinterface

// File: rtl/popcount_sequencer.sv
// rtl/popcount_sequencer.sv - chunk-serial popcount of a wide word through one shared count_ones
// Optional early exit on an all-zero remainder is enabled by defining POPCOUNT_EARLY_EXIT_EN.
module count_ones #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 4
) (
  input  logic [WIDTH-1:0]     bits,
  output logic [OUT_WIDTH-1:0] ones
);
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + OUT_WIDTH'(bits[i]);
    end
  end
endmodule

module popcount_sequencer #(
  parameter int WORD_WIDTH  = 64,
  parameter int CHUNK_WIDTH = 8,
  parameter int COUNT_WIDTH = 7
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  popcount_sequencer_if.slave bus
);
  localparam int N           = WORD_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W       = (N > 1) ? $clog2(N) : 1;
  localparam int CHUNK_CNT_W = $clog2(CHUNK_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_d;
  logic [WORD_WIDTH-1:0]  shreg;
  logic [COUNT_WIDTH-1:0] acc;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [IDX_W-1:0]       idx;
  logic [CHUNK_CNT_W-1:0] chunk_ones;
  logic [COUNT_WIDTH-1:0] sum;
  logic                   last;
  logic                   load;
  logic                   step;

  count_ones #(
    .WIDTH    (CHUNK_WIDTH),
    .OUT_WIDTH(CHUNK_CNT_W)
  ) u_count_ones (
    .bits(shreg[CHUNK_WIDTH-1:0]),
    .ones(chunk_ones)
  );

  assign sum = acc + COUNT_WIDTH'(chunk_ones);

`ifdef POPCOUNT_EARLY_EXIT_EN
  // Stop as soon as nothing nonzero remains above the chunk being counted.
  assign last = (idx == IDX_W'(N - 1)) || ((shreg >> CHUNK_WIDTH) == '0);
`else
  assign last = (idx == IDX_W'(N - 1));
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d             = state;
    load                = 1'b0;
    step                = 1'b0;
    bus.word_ready_out  = 1'b0;
    bus.count_valid_out = 1'b0;
    bus.busy_out        = 1'b0;
    case (state)
      IDLE: begin
        bus.word_ready_out = 1'b1;
        if (bus.word_valid_in) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.busy_out = 1'b1;
        step         = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.busy_out        = 1'b1;
        bus.count_valid_out = 1'b1;
        // Ready follows the consumer so a new word can chain straight into RUN.
        bus.word_ready_out  = bus.count_ready_in;
        if (bus.count_ready_in) begin
          if (bus.word_valid_in) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shreg   <= '0;
      acc     <= '0;
      idx     <= '0;
      count_q <= '0;
    end else if (load) begin
      shreg <= bus.word_in;
      acc   <= '0;
      idx   <= '0;
    end else if (step) begin
      shreg <= shreg >> CHUNK_WIDTH;
      acc   <= sum;
      idx   <= idx + 1'b1;
      if (last) begin
        count_q <= sum;
      end
    end
  end

  assign bus.count_out = count_q;

endmodule

// File: tb/tb_popcount_sequencer.sv
// tb/tb_popcount_sequencer.sv - scoreboard bench for popcount_sequencer against a popcount/latency model
module tb_popcount_sequencer;
  localparam int WW = 64;
  localparam int CW = 8;
  localparam int N  = WW / CW;

  typedef struct {
    logic [6:0] cnt;
    int         accept;
    int         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  bit   rand_mode;
  exp_t sb[$];

  popcount_sequencer_if #(.WORD_WIDTH(WW), .COUNT_WIDTH(7)) pif ();

  popcount_sequencer dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (pif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Latency in cycles from acceptance to count valid, derived from the word itself.
  function automatic int exp_lat(input logic [WW-1:0] w);
`ifdef POPCOUNT_EARLY_EXIT_EN
    int hi;
    hi = 0;
    for (int c = 0; c < N; c++) begin
      if (w[c*CW +: CW] != '0) hi = c;
    end
    return hi + 1;
`else
    return N;
`endif
  endfunction

  task automatic monitor();
    bit         prev_valid;
    bit         prev_hs;
    logic [6:0] held;
    exp_t       e;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        check("word_ready_rule",
              pif.word_ready_out == (!pif.busy_out || (pif.count_valid_out && pif.count_ready_in)),
              pif.word_ready_out, !pif.busy_out || (pif.count_valid_out && pif.count_ready_in));
        if (prev_hs) check("valid_drop_after_handshake", !pif.count_valid_out, pif.count_valid_out, 0);
        if (pif.count_valid_out && !prev_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_count", 1'b0, pif.count_out, -1);
          end else begin
            e = sb.pop_front();
            check("count_value", pif.count_out == e.cnt, pif.count_out, e.cnt);
            check("latency", (cyc - e.accept) == e.lat, cyc - e.accept, e.lat);
          end
          held = pif.count_out;
        end else if (pif.count_valid_out && prev_valid) begin
          check("count_stable", pif.count_out == held, pif.count_out, held);
        end
        prev_valid = pif.count_valid_out;
        prev_hs    = pif.count_valid_out && pif.count_ready_in;
      end
    end
  endtask

  task automatic send(input logic [WW-1:0] w, output int acc_cyc);
    exp_t e;
    pif.word_in       = w;
    pif.word_valid_in = 1'b1;
    acc_cyc           = -1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (pif.word_ready_out) begin
        e.cnt    = 7'($countones(w));
        e.accept = cyc + 1;
        e.lat    = exp_lat(w);
        sb.push_back(e);
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        pif.word_valid_in = 1'b0;
        break;
      end
    end
    if (acc_cyc < 0) check("send_timeout", 1'b0, 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !pif.count_valid_out) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 1'b0, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count_out"}, pif.count_out == 0, pif.count_out, 0);
    check({tag, "_count_valid"}, pif.count_valid_out == 0, pif.count_valid_out, 0);
    check({tag, "_busy"}, pif.busy_out == 0, pif.busy_out, 0);
    check({tag, "_word_ready"}, pif.word_ready_out == 1, pif.word_ready_out, 1);
  endtask

  initial begin
    int a0, a1, a2, dummy;
    bit seen;
    logic [WW-1:0] w;
    checks            = 0;
    failures          = 0;
    cyc               = 0;
    rand_mode         = 1'b0;
    rst_n             = 1'b0;
    pif.word_in       = '0;
    pif.word_valid_in = 1'b0;
    pif.count_ready_in = 1'b1;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(posedge clk);
        #1;
        if (rand_mode) pif.count_ready_in = 1'($urandom_range(0, 1));
      end
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(64'hFFFF_FFFF_FFFF_FFFF, dummy);
    drain();
    send(64'h0123_4567_89AB_CDEF, dummy);
    drain();
    send(64'h0, dummy);
    drain();

    send(64'h1, a0);
    send(64'h3, a1);
    send(64'h7, a2);
    check("b2b_interval_1", (a1 - a0) == exp_lat(64'h1) + 1, a1 - a0, exp_lat(64'h1) + 1);
    check("b2b_interval_2", (a2 - a1) == exp_lat(64'h3) + 1, a2 - a1, exp_lat(64'h3) + 1);
    drain();

    pif.count_ready_in = 1'b0;
    send(64'h00F0_F0F0_0000_0F0F, dummy);
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (pif.count_valid_out) begin
        seen = 1'b1;
        break;
      end
    end
    check("backpressure_valid_seen", seen, seen, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_held", pif.count_valid_out == 1, pif.count_valid_out, 1);
      check("bp_word_ready", pif.word_ready_out == 0, pif.word_ready_out, 0);
      check("bp_busy", pif.busy_out == 1, pif.busy_out, 1);
    end
    @(posedge clk);
    #1;
    pif.count_ready_in = 1'b1;
    drain();

    send(64'h0000_FFFF_0000_FFFF, dummy);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(64'hAAAA_5555_0000_0001, dummy);
    drain();

    send(64'h0000_0000_0000_00FF, dummy);
    drain();
    send(64'h8000_0000_0000_0000, dummy);
    drain();

    rand_mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      w = {$urandom, $urandom};
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 2) == 0) w[c*CW +: CW] = '0;
      end
      send(w, dummy);
    end
    rand_mode = 1'b0;
    pif.count_ready_in = 1'b1;
    drain();

    check("scoreboard_empty", sb.size() == 0, sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
